// File: rtl/frog_pkg.sv
// Shared types for the frog movement controller: step directions, FSM states, key-press pick.
// Pure declarations; no timing or flow control.
package frog_pkg;

    typedef enum logic [1:0] {
        DOWN  = 2'd0,
        UP    = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        PLAY    = 3'd0,
        COOL    = 3'd1,
        DYING   = 3'd2,
        RESPAWN = 3'd3,
        OVER    = 3'd4
    } ctrl_state_t;

    localparam int STEP_PX = 40;

    typedef struct packed {
        logic vld;
        dir_t dir;
    } press_t;

    // Key edge vector is indexed by dir_t, so the lowest set bit wins: down > up > left > right.
    function automatic press_t pick_press(input logic [3:0] edges);
        press_t p;
        p.vld = |edges;
        p.dir = DOWN;
        if (edges[0])      p.dir = DOWN;
        else if (edges[1]) p.dir = UP;
        else if (edges[2]) p.dir = LEFT;
        else if (edges[3]) p.dir = RIGHT;
        return p;
    endfunction

endpackage

// File: rtl/frog_key_fifo.sv
// Small generic FIFO with synchronous flush; read data is the head entry, valid while !empty.
// Write accepted when not full, or when full with a read in the same cycle.
module frog_key_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic         frame_clk,
    input  logic         Reset_n,
    input  logic         flush,
    input  logic         wr_en,
    input  logic [W-1:0] wr_dat,
    input  logic         rd_en,
    output logic [W-1:0] rd_dat,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          do_wr, do_rd;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign do_rd  = rd_en && !empty;
    assign do_wr  = wr_en && (!full || do_rd);
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= next_ptr(wr_ptr);
            if (do_rd) rd_ptr <= next_ptr(rd_ptr);
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge frame_clk) begin
        if (do_wr) mem[wr_ptr] <= wr_dat;
    end

endmodule

// File: rtl/frog_move_ctrl.sv
// Frog step/life/score controller; a step issues two frames after the key edge is sampled.
// No backpressure: presses during cooldown are dropped, or queued 4-deep with FROG_KEY_QUEUE_EN.
module frog_move_ctrl
    import frog_pkg::*;
#(
    parameter int LIVES_INIT      = 3,
    parameter int COOLDOWN_FRAMES = 4,
    parameter int DEATH_FRAMES    = 30
) (
    input  logic        frame_clk,
    input  logic        Reset_n,
    input  logic        up,
    input  logic        down,
    input  logic        left,
    input  logic        right,
    input  logic        collide,
    input  logic        goal,
    input  logic        on_pad,
    input  logic [10:0] pad_motion_x,
    output logic        step_valid,
    output dir_t        step_dir,
    output logic [10:0] carry_x,
    output logic        respawn,
    output logic [1:0]  lives,
    output logic [7:0]  score,
    output logic        game_over,
    output logic [2:0]  ctrl_state
);

    localparam int CW = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;
    localparam int DW = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;

    ctrl_state_t   state;
    logic [CW-1:0] cool_cnt;
    logic [DW-1:0] die_cnt;
    logic [3:0]    key_q, key_now, key_edge;
    press_t        press;
    logic          live_st, pend_vld, pend_pop, pend_flush;
    dir_t          pend_dir;

    assign key_now    = {right, left, up, down};
    assign key_edge   = key_now & ~key_q;
    assign press      = pick_press(key_edge);
    assign live_st    = (state == PLAY) || (state == COOL);
    assign pend_flush = !live_st || collide;
    assign pend_pop   = (state == PLAY) && pend_vld && !collide && !goal;

    assign carry_x    = (on_pad && live_st) ? pad_motion_x : 11'd0;
    assign game_over  = (state == OVER);
    assign ctrl_state = state;

`ifdef FROG_KEY_QUEUE_EN
    logic       fifo_empty, fifo_full;
    logic [1:0] fifo_rd_dat;

    frog_key_fifo #(.DEPTH(4), .W(2)) u_key_fifo (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .flush     (pend_flush),
        .wr_en     (live_st && press.vld),
        .wr_dat    (press.dir),
        .rd_en     (pend_pop),
        .rd_dat    (fifo_rd_dat),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign pend_vld = !fifo_empty;
    assign pend_dir = dir_t'(fifo_rd_dat);
`else
    logic pend_vld_q;
    dir_t pend_dir_q;

    // Only one press can wait; anything arriving while it waits or during COOL is dropped.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pend_vld_q <= 1'b0;
            pend_dir_q <= DOWN;
        end else if (pend_flush || pend_pop) begin
            pend_vld_q <= 1'b0;
        end else if ((state == PLAY) && press.vld && !pend_vld_q) begin
            pend_vld_q <= 1'b1;
            pend_dir_q <= press.dir;
        end
    end

    assign pend_vld = pend_vld_q;
    assign pend_dir = pend_dir_q;
`endif

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= RESPAWN;
            lives      <= 2'(LIVES_INIT);
            score      <= 8'd0;
            step_valid <= 1'b0;
            step_dir   <= DOWN;
            respawn    <= 1'b0;
            cool_cnt   <= '0;
            die_cnt    <= '0;
            key_q      <= 4'd0;
        end else begin
            step_valid <= 1'b0;
            respawn    <= 1'b0;
            key_q      <= key_now;
            case (state)
                PLAY, COOL: begin
                    if (collide) begin
                        state   <= DYING;
                        die_cnt <= DW'(DEATH_FRAMES - 1);
                        lives   <= (lives == 2'd0) ? 2'd0 : lives - 2'd1;
                    end else if (goal) begin
                        score <= (score == 8'd255) ? 8'd255 : score + 8'd1;
                        state <= RESPAWN;
                    end else if (state == PLAY) begin
                        if (pend_vld) begin
                            step_valid <= 1'b1;
                            step_dir   <= pend_dir;
                            cool_cnt   <= CW'(COOLDOWN_FRAMES - 1);
                            state      <= COOL;
                        end
                    end else begin
                        // Leaving on the frame the count reaches zero spaces steps COOLDOWN_FRAMES apart.
                        if (cool_cnt <= CW'(1)) state <= PLAY;
                        if (cool_cnt != '0) cool_cnt <= cool_cnt - CW'(1);
                    end
                end
                DYING: begin
                    if (die_cnt <= DW'(1)) state <= (lives == 2'd0) ? OVER : RESPAWN;
                    if (die_cnt != '0) die_cnt <= die_cnt - DW'(1);
                end
                RESPAWN: begin
                    respawn <= 1'b1;
                    key_q   <= 4'd0;
                    state   <= PLAY;
                end
                OVER: begin
                    if (press.vld) begin
                        lives <= 2'(LIVES_INIT);
                        score <= 8'd0;
                        state <= RESPAWN;
                    end
                end
                default: state <= RESPAWN;
            endcase
        end
    end

endmodule

// File: tb/tb_frog_move_ctrl.sv
// Scoreboard bench for frog_move_ctrl: expected step/respawn frames are queued at stimulus time
// and matched when the outputs pulse; level outputs are checked against constants.
module tb_frog_move_ctrl;
    import frog_pkg::*;

    logic        frame_clk = 1'b0;
    logic        Reset_n;
    logic        up, down, left, right, collide, goal, on_pad;
    logic [10:0] pad_motion_x;
    logic        step_valid;
    dir_t        step_dir;
    logic [10:0] carry_x;
    logic        respawn;
    logic [1:0]  lives;
    logic [7:0]  score;
    logic        game_over;
    logic [2:0]  ctrl_state;

    int frame_no = 0;
    int n_chk    = 0;
    int n_fail   = 0;

    typedef struct {
        int   frame;
        dir_t dir;
    } step_exp_t;

    step_exp_t step_q[$];
    int        rsp_q[$];

    frog_move_ctrl dut (
        .frame_clk    (frame_clk),
        .Reset_n      (Reset_n),
        .up           (up),
        .down         (down),
        .left         (left),
        .right        (right),
        .collide      (collide),
        .goal         (goal),
        .on_pad       (on_pad),
        .pad_motion_x (pad_motion_x),
        .step_valid   (step_valid),
        .step_dir     (step_dir),
        .carry_x      (carry_x),
        .respawn      (respawn),
        .lives        (lives),
        .score        (score),
        .game_over    (game_over),
        .ctrl_state   (ctrl_state)
    );

    always #5 frame_clk = ~frame_clk;
    always @(posedge frame_clk) frame_no <= frame_no + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (frame %0d)", tag, act, exp, frame_no);
        end
    endtask

    task automatic next_frame();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic wait_frames(input int n);
        repeat (n) next_frame();
    endtask

    task automatic push_step(input int f, input dir_t d);
        step_exp_t e;
        e.frame = f;
        e.dir   = d;
        step_q.push_back(e);
    endtask

    // Pulse outputs are matched against the scoreboard on the falling edge.
    always @(negedge frame_clk) begin
        if (Reset_n) begin
            if (step_valid) begin
                if (step_q.size() == 0) begin
                    check_eq("step_unexpected", 32'(step_valid), 32'd0);
                end else begin
                    step_exp_t e;
                    e = step_q.pop_front();
                    check_eq("step_frame", frame_no, e.frame);
                    check_eq("step_dir", 32'(step_dir), 32'(e.dir));
                end
            end
            if (respawn) begin
                if (rsp_q.size() == 0) begin
                    check_eq("respawn_unexpected", 32'(respawn), 32'd0);
                end else begin
                    int f;
                    f = rsp_q.pop_front();
                    check_eq("respawn_frame", frame_no, f);
                end
            end
        end
    end

    initial begin
        int n;
        Reset_n = 1'b0;
        {up, down, left, right, collide, goal} = '0;
        on_pad       = 1'b1;
        pad_motion_x = 11'h7FE;
        wait_frames(3);

        check_eq("rst_step_valid", 32'(step_valid), 32'd0);
        check_eq("rst_respawn", 32'(respawn), 32'd0);
        check_eq("rst_lives", 32'(lives), 32'd3);
        check_eq("rst_score", 32'(score), 32'd0);
        check_eq("rst_game_over", 32'(game_over), 32'd0);
        check_eq("rst_carry_x", 32'(carry_x), 32'd0);
        check_eq("rst_state", 32'(ctrl_state), 32'(RESPAWN));

        Reset_n = 1'b1;
        rsp_q.push_back(frame_no + 1);
        on_pad = 1'b0;
        wait_frames(2);
        check_eq("play_state", 32'(ctrl_state), 32'(PLAY));

        // Press and hold: one step only.
        up = 1'b1;
        push_step(frame_no + 2, UP);
        wait_frames(10);
        up = 1'b0;
        wait_frames(6);
        check_eq("hold_step_q_empty", step_q.size(), 0);

        // Left then right on consecutive frames.
        left = 1'b1;
        push_step(frame_no + 2, LEFT);
`ifdef FROG_KEY_QUEUE_EN
        push_step(frame_no + 6, RIGHT);
`endif
        next_frame();
        left  = 1'b0;
        right = 1'b1;
        next_frame();
        right = 1'b0;
        wait_frames(8);
        check_eq("cool_step_q_empty", step_q.size(), 0);

        // Pad carry while playing.
        on_pad = 1'b1;
        #1;
        check_eq("carry_play", 32'(carry_x), 32'h7FE);

        // Collide, goal and up in one frame: collide wins.
        collide = 1'b1;
        goal    = 1'b1;
        up      = 1'b1;
        n = frame_no;
        rsp_q.push_back(n + 31);
        next_frame();
        collide = 1'b0;
        goal    = 1'b0;
        up      = 1'b0;
        check_eq("collide_lives", 32'(lives), 32'd2);
        check_eq("collide_score", 32'(score), 32'd0);
        for (int k = 0; k < 29; k++) begin
            check_eq("dying_state", 32'(ctrl_state), 32'(DYING));
            check_eq("dying_carry", 32'(carry_x), 32'd0);
            next_frame();
        end
        on_pad = 1'b0;
        wait_frames(3);
        check_eq("collide_rsp_q_empty", rsp_q.size(), 0);

        // Goal scores and respawns without costing a life.
        goal = 1'b1;
        rsp_q.push_back(frame_no + 2);
        next_frame();
        goal = 1'b0;
        wait_frames(3);
        check_eq("goal_score", 32'(score), 32'd1);
        check_eq("goal_lives", 32'(lives), 32'd2);

        // Asynchronous reset while cooling down.
        left = 1'b1;
        next_frame();
        left = 1'b0;
        next_frame();
        check_eq("pre_rst_step", 32'(step_valid), 32'd1);
        check_eq("pre_rst_state", 32'(ctrl_state), 32'(COOL));
        #1;
        Reset_n = 1'b0;
        #1;
        check_eq("arst_step_valid", 32'(step_valid), 32'd0);
        check_eq("arst_state", 32'(ctrl_state), 32'(RESPAWN));
        check_eq("arst_score", 32'(score), 32'd0);
        check_eq("arst_lives", 32'(lives), 32'd3);
        #4;
        Reset_n = 1'b1;
        rsp_q.push_back(frame_no + 1);
        wait_frames(4);
        check_eq("arst_rsp_q_empty", rsp_q.size(), 0);

        // Three collisions end the game.
        for (int c = 0; c < 3; c++) begin
            collide = 1'b1;
            if (c < 2) rsp_q.push_back(frame_no + 31);
            next_frame();
            collide = 1'b0;
            wait_frames(32);
        end
        check_eq("over_game_over", 32'(game_over), 32'd1);
        check_eq("over_lives", 32'(lives), 32'd0);
        check_eq("over_state", 32'(ctrl_state), 32'(OVER));
        on_pad  = 1'b1;
        collide = 1'b1;
        next_frame();
        collide = 1'b0;
        check_eq("over_carry", 32'(carry_x), 32'd0);
        check_eq("over_lives_sat", 32'(lives), 32'd0);

        // Restart from game over with a down press.
        down = 1'b1;
        rsp_q.push_back(frame_no + 2);
        next_frame();
        down   = 1'b0;
        on_pad = 1'b0;
        check_eq("restart_lives", 32'(lives), 32'd3);
        check_eq("restart_score", 32'(score), 32'd0);
        check_eq("restart_game_over", 32'(game_over), 32'd0);
        wait_frames(3);

        // Score saturates at 255.
        for (int g = 0; g < 256; g++) begin
            goal = 1'b1;
            rsp_q.push_back(frame_no + 2);
            next_frame();
            goal = 1'b0;
            next_frame();
        end
        wait_frames(2);
        check_eq("score_sat", 32'(score), 32'd255);
        check_eq("score_sat_lives", 32'(lives), 32'd3);

        wait_frames(3);
        check_eq("final_step_q_empty", step_q.size(), 0);
        check_eq("final_rsp_q_empty", rsp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
